// File: rtl/dht11_poll_ctrl.sv
// Purpose: periodic / on-demand poll sequencer for a DHT11 reader (IDLE -> KICK -> WAIT).
// Latency: poll every PERIOD_CYC cycles or one cycle after trig; results one cycle after rdr_ready.
// Backpressure: none; one trig arriving while busy is queued, any further trigs are dropped.
module dht11_poll_ctrl #(
  parameter int PERIOD_CYC  = 50_000_000,
  parameter int TIMEOUT_CYC = 40_000_000,
  parameter int RST_CYC     = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       trig,
  output logic       rdr_rst,
  input  logic       rdr_ready,
  input  logic [7:0] rdr_temp,
  output logic [7:0] temp,
  output logic       valid,
  output logic       new_data,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int PW = $clog2(PERIOD_CYC + 1);
  localparam int KW = $clog2(RST_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0] PER_LAST   = PW'(PERIOD_CYC - 1);
  localparam logic [KW-1:0] KICK_LAST  = KW'(RST_CYC - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, KICK, WAIT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] period_cnt;
  logic [KW-1:0] kick_cnt;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] retry_cnt;
  logic          pending;

  logic start;      // leave IDLE this cycle
  logic kick_done;  // last KICK cycle
  logic rd_ok;      // frame accepted this cycle
  logic tmo;        // WAIT expired without a frame
  logic retry_more; // a timeout still has retries left

  // The reader is held in reset everywhere except WAIT, so it stays parked between polls.
  assign rdr_rst = (state != WAIT);
  assign busy    = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle event decode; rdr_ready takes priority over a timeout.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    kick_done  = 1'b0;
    rd_ok      = 1'b0;
    tmo        = 1'b0;
    retry_more = (retry_cnt < RETRY_LAST);
    case (state)
      IDLE: begin
        if (trig || pending || (enable && (period_cnt == PER_LAST))) begin
          start     = 1'b1;
          state_nxt = KICK;
        end
      end
      KICK: begin
        if (kick_cnt == KICK_LAST) begin
          kick_done = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (rdr_ready) begin
          rd_ok     = 1'b1;
          state_nxt = IDLE;
        end else if (to_cnt == TO_LAST) begin
          tmo       = 1'b1;
          state_nxt = retry_more ? KICK : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Period counter: runs only in IDLE with enable, so every return to IDLE restarts the full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     period_cnt <= '0;
    else if ((state != IDLE) || start || !enable) period_cnt <= '0;
    else                                         period_cnt <= period_cnt + 1'b1;
  end

  // KICK length and WAIT timeout counters; both sit at zero outside their own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kick_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      kick_cnt <= ((state == KICK) && !kick_done) ? kick_cnt + 1'b1 : '0;
      to_cnt   <= ((state == WAIT) && (state_nxt == WAIT)) ? to_cnt + 1'b1 : '0;
    end
  end

  // Retry bookkeeping and the single-entry request queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      if (rd_ok || (tmo && !retry_more)) retry_cnt <= '0;
      else if (tmo)                      retry_cnt <= retry_cnt + 1'b1;
      // In IDLE a pending request always starts a transaction, so it is consumed there.
      if (state == IDLE) pending <= 1'b0;
      else if (trig)     pending <= 1'b1;
    end
  end

  // Result registers and status pulses; a failed poll leaves temp/valid untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp     <= '0;
      valid    <= 1'b0;
      new_data <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      new_data <= rd_ok;
      err      <= tmo && !retry_more;
      if (rd_ok) begin
        temp  <= rdr_temp;
        valid <= 1'b1;
      end
      if (tmo && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// Bench for dht11_poll_ctrl: directed steps, a behavioural DHT11 reader driven by a response plan,
// and a scoreboard of expected new_data/err results checked as the pulses appear.
module tb_dht11_poll_ctrl;

  localparam int PERIOD = 100;
  localparam int TMO    = 50;
  localparam int RSTC   = 4;
  localparam int MAXR   = 2;

  logic       clk = 1'b0;
  logic       rst, enable, trig;
  logic       rdr_rst, rdr_ready, valid, new_data, err, busy;
  logic [7:0] rdr_temp, temp, err_cnt;

  typedef struct { int d; logic [7:0] t; } plan_t;       // d = WAIT cycle where ready rises, -1 = never
  typedef struct { bit is_err; logic [7:0] t; } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  plan_t cur_p;
  exp_t  cur_e;

  int n_assert = 0;
  int n_fail = 0;
  int nd_pulses = 0;
  int err_pulses = 0;
  int attempts = 0;
  int a0, e0;

  dht11_poll_ctrl #(
    .PERIOD_CYC(PERIOD), .TIMEOUT_CYC(TMO), .RST_CYC(RSTC), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig),
    .rdr_rst(rdr_rst), .rdr_ready(rdr_ready), .rdr_temp(rdr_temp),
    .temp(temp), .valid(valid), .new_data(new_data), .err(err),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k;
    k = 0;
    while (busy && (k < bound)) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // Called on the first negedge after KICK is entered: RSTC cycles of rdr_rst high, then WAIT.
  task automatic kick_check(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_kick_rst"}, 32'(rdr_rst), 32'd1);
    cyc(RSTC - 1);
    check({tag, "_kick_last"}, 32'(rdr_rst), 32'd1);
    cyc(1);
    check({tag, "_wait_rst_low"}, 32'(rdr_rst), 32'd0);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    cyc(1);
    trig = 1'b0;
  endtask

  // Reader model: takes the next plan entry each time it is released from reset.
  int   rd_d = -1;
  int   rd_cnt = 0;
  logic rr_prev = 1'b1;
  initial begin
    rdr_ready = 1'b0;
    rdr_temp  = 8'h00;
  end
  always @(negedge clk) begin
    if (rdr_rst) begin
      rdr_ready = 1'b0;
      rd_cnt    = 0;
    end else begin
      if (rr_prev) begin
        attempts++;
        if (plan_q.size() > 0) begin
          cur_p    = plan_q.pop_front();
          rd_d     = cur_p.d;
          rdr_temp = cur_p.t;
        end else begin
          rd_d = -1;
        end
        rd_cnt = 0;
      end
      rdr_ready = (rd_d >= 0) && (rd_cnt >= rd_d);
      rd_cnt++;
    end
    rr_prev = rdr_rst;
  end

  // Scoreboard: every new_data/err pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && (new_data || err)) begin
      if (new_data) nd_pulses++;
      if (err) err_pulses++;
      check("pulse_exclusive", 32'(new_data & err), 32'd0);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_pulse: observed new_data=%0b err=%0b expected no pulse", new_data, err);
      end else begin
        cur_e = exp_q.pop_front();
        check("pulse_kind", 32'(err), 32'(cur_e.is_err));
        check("pulse_temp", 32'(temp), 32'(cur_e.t));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; trig = 1'b0;
    cyc(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdr_rst", 32'(rdr_rst), 32'd1);
    check("rst_temp", 32'(temp), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_new_data", 32'(new_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Automatic poll PERIOD cycles after reset release, reader answers 20 cycles into WAIT.
    plan_q.push_back('{20, 8'h19});
    exp_q.push_back('{1'b0, 8'h19});
    enable = 1'b1;
    rst = 1'b0;
    cyc(PERIOD - 1);
    check("t1_no_early_poll", 32'(busy), 32'd0);
    cyc(1);
    kick_check("t1");
    wait_idle("t1_done", 60);
    enable = 1'b0;
    cyc(1);
    check("t1_temp", 32'(temp), 32'h19);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_nd_count", 32'(nd_pulses), 32'd1);

    // Software trigger with enable low, plus trigs during WAIT -> exactly one follow-up.
    plan_q.push_back('{10, 8'h11});
    plan_q.push_back('{5, 8'h22});
    exp_q.push_back('{1'b0, 8'h11});
    exp_q.push_back('{1'b0, 8'h22});
    pulse_trig();
    kick_check("t2");
    pulse_trig();
    cyc(2);
    pulse_trig();
    wait_idle("t2_first_done", 30);
    cyc(1);
    check("t2_followup_busy", 32'(busy), 32'd1);
    wait_idle("t2_second_done", 40);
    cyc(30);
    check("t2_no_third", 32'(busy), 32'd0);
    check("t2_nd_count", 32'(nd_pulses), 32'd3);
    check("t2_temp", 32'(temp), 32'h22);

    // Reader never answers: all attempts time out, one err pulse, data kept.
    a0 = attempts; e0 = err_pulses;
    repeat (MAXR + 1) plan_q.push_back('{-1, 8'h00});
    exp_q.push_back('{1'b1, 8'h22});
    pulse_trig();
    wait_idle("t3_done", 200);
    cyc(1);
    check("t3_attempts", 32'(attempts - a0), 32'(MAXR + 1));
    check("t3_err_cnt", 32'(err_cnt), 32'd3);
    check("t3_err_pulses", 32'(err_pulses - e0), 32'd1);
    check("t3_temp", 32'(temp), 32'h22);
    check("t3_valid", 32'(valid), 32'd1);

    // One timeout, then success on the retry.
    a0 = attempts; e0 = err_pulses;
    plan_q.push_back('{-1, 8'h00});
    plan_q.push_back('{15, 8'h2A});
    exp_q.push_back('{1'b0, 8'h2A});
    pulse_trig();
    wait_idle("t4_done", 200);
    cyc(1);
    check("t4_attempts", 32'(attempts - a0), 32'd2);
    check("t4_err_cnt", 32'(err_cnt), 32'd4);
    check("t4_no_err", 32'(err_pulses - e0), 32'd0);
    check("t4_temp", 32'(temp), 32'h2A);

    // Ready on the exact timeout cycle: data wins, nothing counted.
    a0 = attempts;
    plan_q.push_back('{TMO - 1, 8'h33});
    exp_q.push_back('{1'b0, 8'h33});
    pulse_trig();
    wait_idle("t5_done", 100);
    cyc(1);
    check("t5_attempts", 32'(attempts - a0), 32'd1);
    check("t5_err_cnt", 32'(err_cnt), 32'd4);
    check("t5_temp", 32'(temp), 32'h33);

    // Retry count was cleared by the earlier success: two timeouts then success, no err.
    a0 = attempts; e0 = err_pulses;
    plan_q.push_back('{-1, 8'h00});
    plan_q.push_back('{-1, 8'h00});
    plan_q.push_back('{7, 8'h44});
    exp_q.push_back('{1'b0, 8'h44});
    pulse_trig();
    wait_idle("t6_done", 250);
    cyc(1);
    check("t6_attempts", 32'(attempts - a0), 32'd3);
    check("t6_err_cnt", 32'(err_cnt), 32'd6);
    check("t6_no_err", 32'(err_pulses - e0), 32'd0);
    check("t6_temp", 32'(temp), 32'h44);

    // Reset asserted mid-WAIT, away from a clock edge.
    plan_q.push_back('{-1, 8'h00});
    pulse_trig();
    cyc(RSTC + 10);
    check("t7_in_wait", 32'(rdr_rst), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_rdr_rst", 32'(rdr_rst), 32'd1);
    check("t7_temp", 32'(temp), 32'd0);
    check("t7_valid", 32'(valid), 32'd0);
    check("t7_err_cnt", 32'(err_cnt), 32'd0);
    check("t7_new_data", 32'(new_data), 32'd0);
    check("t7_err", 32'(err), 32'd0);
    cyc(3);
    rst = 1'b0;
    cyc(20);
    check("t7_idle_after", 32'(busy), 32'd0);
    check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("end_plan_q_empty", 32'(plan_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
